// File: rtl/baud_ctrl.sv
// Baud-rate change controller: arbitrates two requesters, drains the UART, loads the divider, waits to settle.
// Optional drain timeout is enabled by defining BAUD_CTRL_TIMEOUT_EN.
module baud_ctrl #(
    parameter int NUM_BAUD       = 5,
    parameter int DEFAULT_BAUD   = 1,
    parameter int SETTLE_TICKS   = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [2:0] req_baud0,
    input  logic [2:0] req_baud1,
    input  logic       tx_busy,
    input  logic       rx_busy,
    input  logic       clk_16bd,
    output logic [1:0] ack,
    output logic [2:0] baud,
    output logic       baud_ready,
    output logic       switching,
    output logic       err_invalid,
    output logic       err_timeout
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_DRAIN, S_APPLY, S_SETTLE, S_DONE} state_t;

    localparam int               CW          = $clog2(SETTLE_TICKS + 1);
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_TICKS - 1);
    localparam logic [3:0]       NUM_CODES   = 4'(NUM_BAUD);
    localparam logic [2:0]       DEF_CODE    = 3'(DEFAULT_BAUD);

    state_t          state_q, state_d;
    logic [2:0]      baud_q, baud_d;
    logic            baud_ready_q, baud_ready_d;
    logic [2:0]      code_q, code_d;
    logic            gnt_q, gnt_d;
    logic            prio_q, prio_d;
    logic            switching_q, switching_d;
    logic            init_q, init_d;
    logic            inv_q, inv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            s1_q, s2_q;
    logic            tick;
    logic            win;
    logic [2:0]      win_code;
    logic            win_bad;

`ifdef BAUD_CTRL_TIMEOUT_EN
    localparam int               TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;
`else
    // Timeout length is meaningless without the timeout build; referenced only to keep it declared.
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    end
`endif

    // Edge detect on the divider tick, registered for timing.
    assign tick = s1_q & ~s2_q;

    // Round-robin winner: contention goes to the priority pointer.
    assign win      = req[0] ? (req[1] ? prio_q : 1'b0) : 1'b1;
    assign win_code = win ? req_baud1 : req_baud0;
    assign win_bad  = ({1'b0, win_code} >= NUM_CODES);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        baud_ready_d = 1'b0;
        code_d       = code_q;
        gnt_d        = gnt_q;
        prio_d       = prio_q;
        switching_d  = switching_q;
        init_d       = init_q;
        inv_d        = inv_q;
        cnt_d        = cnt_q;
`ifdef BAUD_CTRL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_INIT: begin
                baud_d       = DEF_CODE;
                baud_ready_d = 1'b1;
                init_d       = 1'b1;
                cnt_d        = '0;
                state_d      = S_SETTLE;
            end
            S_IDLE: begin
                if (|req) begin
                    gnt_d       = win;
                    prio_d      = ~win;
                    code_d      = win_code;
                    switching_d = 1'b1;
                    init_d      = 1'b0;
                    inv_d       = win_bad;
`ifdef BAUD_CTRL_TIMEOUT_EN
                    tmo_cnt_d   = '0;
                    tmo_d       = 1'b0;
`endif
                    state_d     = (win_bad || (win_code == baud_q)) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    baud_d       = code_q;
                    baud_ready_d = 1'b1;
                    state_d      = S_APPLY;
                end
`ifdef BAUD_CTRL_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_APPLY: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = init_q ? S_IDLE : S_DONE;
                        init_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                switching_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            baud_q       <= DEF_CODE;
            baud_ready_q <= 1'b0;
            code_q       <= DEF_CODE;
            gnt_q        <= 1'b0;
            prio_q       <= 1'b0;
            switching_q  <= 1'b0;
            init_q       <= 1'b0;
            inv_q        <= 1'b0;
            cnt_q        <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
`ifdef BAUD_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            baud_ready_q <= baud_ready_d;
            code_q       <= code_d;
            gnt_q        <= gnt_d;
            prio_q       <= prio_d;
            switching_q  <= switching_d;
            init_q       <= init_d;
            inv_q        <= inv_d;
            cnt_q        <= cnt_d;
            s1_q         <= clk_16bd;
            s2_q         <= s1_q;
`ifdef BAUD_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign ack         = (state_q == S_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign baud        = baud_q;
    assign baud_ready  = baud_ready_q;
    assign switching   = switching_q;
    assign err_invalid = (state_q == S_DONE) & inv_q;
`ifdef BAUD_CTRL_TIMEOUT_EN
    assign err_timeout = (state_q == S_DONE) & tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_baud_ctrl.sv
// Scoreboard bench for baud_ctrl: drivers queue expected strobes/acks, a monitor pops and compares them.
module tb_baud_ctrl;

    typedef struct packed {
        logic       is_ack;
        logic [2:0] baud;
        logic [1:0] ack;
        logic       inv;
        logic       tmo;
        logic       chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [2:0] req_baud0 = 3'd0;
    logic [2:0] req_baud1 = 3'd0;
    logic       tx_busy = 1'b0;
    logic       rx_busy = 1'b0;
    logic       clk_16bd = 1'b0;
    logic [1:0] ack;
    logic [2:0] baud;
    logic       baud_ready;
    logic       switching;
    logic       err_invalid;
    logic       err_timeout;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ticks = 0;
    time  last_strobe_t = 0;
    time  fall_t = 0;

    baud_ctrl #(
        .NUM_BAUD(5), .DEFAULT_BAUD(1), .SETTLE_TICKS(32), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_baud0(req_baud0), .req_baud1(req_baud1),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .clk_16bd(clk_16bd),
        .ack(ack), .baud(baud), .baud_ready(baud_ready), .switching(switching),
        .err_invalid(err_invalid), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // 16x tick: one-cycle pulse every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 clk_16bd = 1'b1;
            @(posedge clk);
            #1 clk_16bd = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic push_s(input logic [2:0] b);
        exp_t e;
        e = '0;
        e.baud = b;
        q.push_back(e);
    endtask

    task automatic push_a(input logic [1:0] a, input logic [2:0] b, input logic inv,
                          input logic tmo, input logic chk);
        exp_t e;
        e.is_ack = 1'b1;
        e.baud   = b;
        e.ack    = a;
        e.inv    = inv;
        e.tmo    = tmo;
        e.chk    = chk;
        q.push_back(e);
    endtask

    // Wait for an ack pulse; reports cycles taken and switching drop-outs while waiting.
    task automatic wait_ack(input int budget, output logic [1:0] got, output int cyc, output int gaps);
        bit seen_sw;
        got = 2'b00;
        cyc = 0;
        gaps = 0;
        seen_sw = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack != 2'b00) begin
                got = ack;
                return;
            end
            if (switching) seen_sw = 1;
            else if (seen_sw) gaps++;
        end
        n_chk++;
        n_fail++;
        $display("FAIL ack_wait: no ack within %0d cycles", budget);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes baud_ready or pulses ack.
    initial begin
        exp_t e;
        logic prev_br;
        logic prev_c16;
        prev_br = 1'b0;
        prev_c16 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (baud_ready) ticks = 0;
                if (clk_16bd && !prev_c16) ticks++;
                if (baud_ready) begin
                    check("strobe_not_back_to_back", {31'd0, prev_br}, 32'd0);
                    last_strobe_t = $time;
                    if (q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        check("strobe_kind", {31'd0, e.is_ack}, 32'd0);
                        check("strobe_baud", {29'd0, baud}, {29'd0, e.baud});
                    end
                end
                if (ack != 2'b00) begin
                    if (q.size() == 0) check("unexpected_ack", {30'd0, ack}, 32'd0);
                    else begin
                        e = q.pop_front();
                        check("ack_kind", {31'd0, e.is_ack}, 32'd1);
                        check("ack_value", {30'd0, ack}, {30'd0, e.ack});
                        check("ack_err_invalid", {31'd0, err_invalid}, {31'd0, e.inv});
                        check("ack_err_timeout", {31'd0, err_timeout}, {31'd0, e.tmo});
                        check("ack_baud", {29'd0, baud}, {29'd0, e.baud});
                        check("ack_switching", {31'd0, switching}, 32'd1);
                        if (e.chk) check_rng("settle_ticks", ticks, 32, 33);
                    end
                end
            end
            prev_br = baud_ready;
            prev_c16 = clk_16bd;
        end
    end

    initial begin
        logic [1:0] got;
        int cyc;
        int gaps;
        logic [2:0] cb;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_baud", {29'd0, baud}, 32'd1);
        check("rst_baud_ready", {31'd0, baud_ready}, 32'd0);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_switching", {31'd0, switching}, 32'd0);
        check("rst_errs", {30'd0, err_invalid, err_timeout}, 32'd0);
        push_s(3'd1);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("init_idle_switching", {31'd0, switching}, 32'd0);
        check("init_baud", {29'd0, baud}, 32'd1);

        // Contention right after reset: requester 0 first.
        push_s(3'd2); push_a(2'b01, 3'd2, 0, 0, 1);
        push_s(3'd4); push_a(2'b10, 3'd4, 0, 0, 1);
        req_baud0 = 3'd2; req_baud1 = 3'd4; req = 2'b11;
        wait_ack(2000, got, cyc, gaps);
        check("rr_first", {30'd0, got}, 32'd1);
        req[0] = 1'b0;
        wait_ack(2000, got, cyc, gaps);
        check("rr_second", {30'd0, got}, 32'd2);
        req[1] = 1'b0;

        // Plain change on requester 0, switching held throughout.
        push_s(3'd3); push_a(2'b01, 3'd3, 0, 0, 1);
        req_baud0 = 3'd3; req = 2'b01;
        wait_ack(2000, got, cyc, gaps);
        req = 2'b00;
        check("single_ack", {30'd0, got}, 32'd1);
        check("single_switching_gaps", gaps, 32'd0);

        // Out-of-range code.
        push_a(2'b10, 3'd3, 1, 0, 0);
        req_baud1 = 3'd6; req = 2'b10;
        wait_ack(2000, got, cyc, gaps);
        req = 2'b00;
        check("invalid_ack", {30'd0, got}, 32'd2);

        // Same code as current: ack with no strobe.
        push_a(2'b01, 3'd3, 0, 0, 0);
        req_baud0 = 3'd3; req = 2'b01;
        wait_ack(2000, got, cyc, gaps);
        req = 2'b00;
        check("same_code_ack", {30'd0, got}, 32'd1);

        // Transmitter busy for 500 cycles.
`ifdef BAUD_CTRL_TIMEOUT_EN
        push_a(2'b10, 3'd3, 0, 1, 0);
        cb = 3'd3;
`else
        push_s(3'd0); push_a(2'b10, 3'd0, 0, 0, 1);
        cb = 3'd0;
`endif
        tx_busy = 1'b1;
        req_baud1 = 3'd0; req = 2'b10;
        fork
            begin
                repeat (500) @(negedge clk);
                tx_busy = 1'b0;
                fall_t = $time;
            end
            begin
                wait_ack(3000, got, cyc, gaps);
                req = 2'b00;
            end
        join
        check("busy_ack", {30'd0, got}, 32'd2);
`ifdef BAUD_CTRL_TIMEOUT_EN
        check_rng("timeout_cycles", cyc, 100, 103);
`else
        check("strobe_after_busy", {31'd0, (last_strobe_t > fall_t)}, 32'd1);
`endif
        check("busy_baud", {29'd0, baud}, {29'd0, cb});

        // Requester 1 served last, so requester 0 wins contention.
        push_s(3'd2); push_a(2'b01, 3'd2, 0, 0, 1);
        push_s(3'd4); push_a(2'b10, 3'd4, 0, 0, 1);
        req_baud0 = 3'd2; req_baud1 = 3'd4; req = 2'b11;
        wait_ack(2000, got, cyc, gaps);
        check("rr2_first", {30'd0, got}, 32'd1);
        req[0] = 1'b0;
        wait_ack(2000, got, cyc, gaps);
        check("rr2_second", {30'd0, got}, 32'd2);
        req[1] = 1'b0;

        // Reset in the middle of settling.
        push_s(3'd1);
        req_baud0 = 3'd1; req = 2'b01;
        repeat (60) @(negedge clk);
        check("midop_switching", {31'd0, switching}, 32'd1);
        rst_n = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("midrst_baud", {29'd0, baud}, 32'd1);
        check("midrst_switching", {31'd0, switching}, 32'd0);
        check("midrst_ack", {30'd0, ack}, 32'd0);
        check("midrst_baud_ready", {31'd0, baud_ready}, 32'd0);
        push_s(3'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_switching", {31'd0, switching}, 32'd0);

        // Pointer back to requester 0 after reset.
        push_s(3'd3); push_a(2'b01, 3'd3, 0, 0, 1);
        push_s(3'd2); push_a(2'b10, 3'd2, 0, 0, 1);
        req_baud0 = 3'd3; req_baud1 = 3'd2; req = 2'b11;
        wait_ack(2000, got, cyc, gaps);
        check("rr3_first", {30'd0, got}, 32'd1);
        req[0] = 1'b0;
        wait_ack(2000, got, cyc, gaps);
        check("rr3_second", {30'd0, got}, 32'd2);
        req[1] = 1'b0;

        repeat (10) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 Parameter NUM_BAUD, default 5: number of valid baud codes; codes 0..NUM_BAUD-1 are legal.
REQ-002 Parameter DEFAULT_BAUD, default 1: baud code applied after reset.
REQ-003 Parameter SETTLE_TICKS, default 32: clk_16bd rising edges waited after a baud change (2 bit periods).
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000: drain timeout in clk cycles; used only when BAUD_CTRL_TIMEOUT_EN is defined.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  2  per-requester baud-change request (bit0 host command path, bit1 local switch); level, held until ack.
REQ-008 req_baud0 / req_baud1  input  3 each  requested baud code for requester 0 / 1; stable while the matching req is high.
REQ-009 tx_busy, rx_busy  input  1 each  UART transmitter / receiver mid-frame.
REQ-010 clk_16bd  input  1  16x baud tick from the clock divider, synchronous to clk.
REQ-011 ack  output  2  one-hot, one-cycle completion pulse to the granted requester.
REQ-012 baud  output  3  baud code driven to the clock divider.
REQ-013 baud_ready  output  1  one-cycle load strobe for baud.
REQ-014 switching  output  1  high from grant until ack; UART front-ends hold off new frames while it is high.
REQ-015 err_invalid, err_timeout  output  1 each  one-cycle error pulses, coincident with ack.

Function
REQ-016 FSM states: INIT, IDLE, DRAIN, APPLY, SETTLE, DONE.
REQ-017 INIT: entered on reset release; drives baud=DEFAULT_BAUD and baud_ready=1 for exactly one cycle, then goes to SETTLE without an ack.
REQ-018 IDLE arbitration: round-robin; with both req high, the requester not granted last wins; the first grant after reset goes to requester 0.
REQ-019 Grant latches the winner's code into an internal register, sets switching, and goes to DRAIN on the next cycle.
REQ-020 Code >= NUM_BAUD: go directly to DONE, pulse err_invalid with ack, leave baud unchanged.
REQ-021 Code equal to the current baud: go directly to DONE, pulse ack, no baud_ready pulse.
REQ-022 DRAIN: remain while tx_busy or rx_busy is high; enter APPLY on the first cycle both are low.
REQ-023 APPLY: drive baud=latched code and baud_ready=1 for exactly one cycle, then enter SETTLE.
REQ-024 SETTLE: clear the counter on entry; count rising edges of clk_16bd (registered edge detect, 1-cycle detect latency); leave when the count reaches SETTLE_TICKS.
REQ-025 SETTLE exit goes to DONE for a request, or to IDLE from INIT.
REQ-026 DONE: pulse ack for the granted requester only, clear switching, and return to IDLE.
REQ-027 A req still high in the cycle after ack is treated as a new request.
REQ-028 req changes during DRAIN, APPLY or SETTLE are ignored; the latched code is used.
REQ-029 A requester that drops req before ack still receives the ack pulse.
REQ-030 baud holds its value between APPLY strobes; baud_ready is never high in two consecutive cycles.
REQ-031 The settle counter is wide enough to hold SETTLE_TICKS without wrap-around.

Reset
REQ-032 While rst_n is low: state=INIT, baud=DEFAULT_BAUD, baud_ready=0, ack=0, switching=0, err_invalid=0, err_timeout=0, all counters cleared, round-robin pointer set to requester 0.
REQ-033 Reset asserted mid-operation aborts the sequence immediately; no ack is issued, and the INIT sequence runs again after release.

Configuration
REQ-034 Macro BAUD_CTRL_TIMEOUT_EN defined: a DRAIN counter that still has busy high after TIMEOUT_CYCLES cycles goes to DONE, pulses err_timeout with ack, and leaves baud unchanged.
REQ-035 Macro BAUD_CTRL_TIMEOUT_EN undefined: DRAIN waits indefinitely, err_timeout is tied to 0, and no timeout counter is synthesised.

Verification
REQ-036 Reset release with clk_16bd ticking -> one baud_ready pulse with baud=1; no ack; IDLE after 32 ticks.
REQ-037 req=01, req_baud0=3, busy low -> baud_ready pulse with baud=3; ack=01 after 32 clk_16bd edges; switching high throughout.
REQ-038 req=11 held with codes 2 and 4 -> requester 0 is served first (baud=2, ack=01), then requester 1 (baud=4, ack=10).
REQ-039 req_baud1=6 -> ack=10 with err_invalid=1; no baud_ready pulse; baud unchanged.
REQ-040 tx_busy high for 500 cycles during a request -> baud_ready occurs only after tx_busy falls; with BAUD_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100 -> err_timeout and ack at cycle 100, with no baud_ready.
REQ-041 rst_n pulsed low during SETTLE -> no ack; baud=DEFAULT_BAUD; the INIT strobe repeats after release.
